// File: rtl/lsu_data_memory.sv
// rtl/lsu_data_memory.sv - byte/half/word data memory with valid/ready requests and pipelined responses
// Errors are resolved at acceptance; the response pipeline only delays {valid, err, rdata}.
module lsu_data_memory #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;
  localparam logic ST_INIT  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic          state_q, state_d;
  logic          started_q;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          accept, size_b, size_h, size_w;
  logic          illegal, misaligned, out_of_range, err;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rd_word, rd_shift, load_data, rd_out;
  logic          clear_we, store_we;

  logic [RD_LATENCY-1:0] pv_q, pe_q;
  logic [31:0]           pd_q [RD_LATENCY];

  // started_q keeps req_ready low during reset even when no sweep is needed
  assign req_ready_o = (state_q == ST_READY) && started_q;
  assign accept      = req_valid_i && req_ready_o;

  assign widx   = req_addr_i[AW+1:2];
  assign lane   = req_addr_i[1:0];
  assign size_b = (req_funct3_i[1:0] == 2'b00);
  assign size_h = (req_funct3_i[1:0] == 2'b01);
  assign size_w = (req_funct3_i == 3'b010);

  assign illegal      = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                        (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
  assign misaligned   = (size_h && lane[0]) || (size_w && (lane != 2'b00));
  assign out_of_range = |req_addr_i[31:AW+2];
  assign err          = illegal || misaligned || out_of_range;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata_i;
    if (size_b) begin
      be        = 4'b0001 << lane;
      wdata_rep = {4{req_wdata_i[7:0]}};
    end else if (size_h) begin
      be        = 4'b0011 << lane;
      wdata_rep = {2{req_wdata_i[15:0]}};
    end
  end

  assign rd_word  = mem_q[widx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = '0;
    case (req_funct3_i)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b101:  load_data = {16'b0, rd_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  assign rd_out   = (req_we_i || err) ? 32'b0 : load_data;
  assign clear_we = rst_ni && (state_q == ST_CLEAR);
  assign store_we = accept && req_we_i && !err;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_CLEAR) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == LAST_WORD) begin
        state_d = ST_READY;
        sweep_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_INIT;
      started_q <= 1'b0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      sweep_q   <= sweep_d;
    end
  end

  // The array has no reset; only the sweep zeroes it
  always_ff @(posedge clk_i) begin
    if (clear_we) begin
      mem_q[sweep_q] <= '0;
    end else if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= accept && err;
      pd_q[0] <= accept ? rd_out : 32'b0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rsp_valid_o = pv_q[RD_LATENCY-1];
  assign rsp_err_o   = pe_q[RD_LATENCY-1];
  assign rsp_rdata_o = pd_q[RD_LATENCY-1];

endmodule
